// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file and the decode stage.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Smallest r with 2**r >= n; a depth of 1 still gets a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset-triggered clear sequencer: walks every entry once, writing zero, and
// holds busy until the last entry has been cleared.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          busy,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr
);

    state_t        state;
    logic [AW-1:0] ptr;

    // Busy drops on the same edge that clears the final entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else if (state == ST_CLEAR) begin
            if (ptr == AW'(DEPTH - 1)) begin
                state <= ST_RUN;
                ptr   <= '0;
                busy  <= 1'b0;
            end else begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    assign clear_we   = (state == ST_CLEAR);
    assign clear_addr = ptr;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with registered multi-port reads and a reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_RD-1:0]       ReadEn,
    input  logic [NUM_RD*AW-1:0]    ReadAddr,
    output logic [NUM_RD*WIDTH-1:0] ReadData,
    output logic [NUM_RD-1:0]       ReadValid,
    input  logic                    RegWrite,
    input  logic [AW-1:0]           WriteAddr,
    input  logic [WIDTH-1:0]        WriteData,
    output logic                    Busy
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             clear_we;
    logic [AW-1:0]    clear_addr;
    logic             user_we;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clock      (Clock),
        .reset      (Reset),
        .busy       (Busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // Out-of-range and hard-wired-zero writes are dropped here, before any bypass.
    assign user_we = !Busy && !Reset && RegWrite
                     && (int'(WriteAddr) < DEPTH)
                     && !((ZERO_REG != 0) && (WriteAddr == '0));

    always_ff @(posedge Clock) begin
        if (clear_we) begin
            regs[clear_addr] <= '0;
        end else if (user_we) begin
            regs[WriteAddr] <= WriteData;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    rd_addr;
        logic [WIDTH-1:0] rd_value;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        assign rd_addr = ReadAddr[p*AW +: AW];

        always_comb begin
            rd_value = '0;
            if ((int'(rd_addr) < DEPTH) && !((ZERO_REG != 0) && (rd_addr == '0))) begin
                rd_value = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
                if (user_we && (WriteAddr == rd_addr)) begin
                    rd_value = WriteData;
                end
`endif
            end
        end

        // Data holds its last value when the port is idle; valid is a one-cycle strobe.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (Busy) begin
                valid_q <= 1'b0;
            end else if (ReadEn[p]) begin
                data_q  <= rd_value;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign ReadData[p*WIDTH +: WIDTH] = data_q;
        assign ReadValid[p]               = valid_q;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param: a 32-deep two-port instance plus a
// 24-deep single-port instance for out-of-range addressing.
module tb_regfile_param;

    logic        Clock;
    logic        Reset;
    logic [1:0]  ReadEn;
    logic [9:0]  ReadAddr;
    logic [63:0] ReadData;
    logic [1:0]  ReadValid;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        Busy;

    logic        ren24;
    logic [4:0]  raddr24;
    logic [31:0] rdata24;
    logic        rvalid24;
    logic        we24;
    logic [4:0]  waddr24;
    logic [31:0] wdata24;
    logic        busy24;

    int vec_count;
    int miss_count;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_EXP = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] SAME_CYCLE_EXP = 32'h0000_0011;
`endif

    regfile_param #(
        .WIDTH    (32),
        .DEPTH    (32),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReadEn    (ReadEn),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .Busy      (Busy)
    );

    regfile_param #(
        .WIDTH    (32),
        .DEPTH    (24),
        .NUM_RD   (1),
        .ZERO_REG (1)
    ) dut24 (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReadEn    (ren24),
        .ReadAddr  (raddr24),
        .ReadData  (rdata24),
        .ReadValid (rvalid24),
        .RegWrite  (we24),
        .WriteAddr (waddr24),
        .WriteData (wdata24),
        .Busy      (busy24)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count = vec_count + 1;
        if (actual !== expected) begin
            miss_count = miss_count + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ren, input logic [4:0] a0,
                                 input logic [4:0] a1, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
        ReadEn    = ren;
        ReadAddr  = {a1, a0};
        RegWrite  = we;
        WriteAddr = wa;
        WriteData = wd;
        tick();
    endtask

    initial begin
        int cnt;
        logic saw_valid;

        vec_count  = 0;
        miss_count = 0;
        Reset      = 1'b0;
        ReadEn     = '0;
        ReadAddr   = '0;
        RegWrite   = 1'b0;
        WriteAddr  = '0;
        WriteData  = '0;
        ren24      = 1'b0;
        raddr24    = '0;
        we24       = 1'b0;
        waddr24    = '0;
        wdata24    = '0;

        // Reset and sweep length
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("reset_busy", 64'(Busy), 64'd1);
        checkOutput("reset_valid", 64'(ReadValid), 64'd0);
        checkOutput("reset_data", ReadData, 64'd0);
        cnt = 0;
        while (Busy && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("sweep_len", 64'(cnt), 64'd32);
        checkOutput("busy24_done", 64'(busy24), 64'd0);

        // Every address reads zero after the sweep
        for (int a = 0; a < 32; a++) begin
            applyStimulus(2'b11, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'd0);
            checkOutput($sformatf("clr_rd_a%0d", a), ReadData, 64'd0);
            checkOutput($sformatf("clr_vld_a%0d", a), 64'(ReadValid), 64'd3);
        end

        // Write then dual-port read of the same address
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        applyStimulus(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
        checkOutput("dual_rd_data", ReadData, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        checkOutput("dual_rd_valid", 64'(ReadValid), 64'd3);
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("idle_valid", 64'(ReadValid), 64'd0);
        checkOutput("idle_hold", ReadData, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

        // Register 0 is hard-wired to zero, even with a same-cycle write
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_1234);
        applyStimulus(2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("zero_reg_rd", 64'(ReadData[31:0]), 64'd0);
        checkOutput("zero_reg_vld", 64'(ReadValid), 64'd1);
        applyStimulus(2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        checkOutput("zero_reg_same", 64'(ReadData[31:0]), 64'd0);

        // Same-cycle read/write collision
        applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h0000_0011);
        applyStimulus(2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 32'hA5A5_A5A5);
        checkOutput("collide_rd", 64'(ReadData[31:0]), 64'(SAME_CYCLE_EXP));
        applyStimulus(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("after_collide", 64'(ReadData[31:0]), 64'hA5A5_A5A5);

        // DEPTH=24: out-of-range reads return zero, writes change nothing
        we24 = 1'b1; waddr24 = 5'd3; wdata24 = 32'h0000_CAFE;
        tick();
        we24 = 1'b0; ren24 = 1'b1; raddr24 = 5'd30;
        tick();
        checkOutput("d24_rd30", 64'(rdata24), 64'd0);
        checkOutput("d24_vld30", 64'(rvalid24), 64'd1);
        ren24 = 1'b0; we24 = 1'b1; waddr24 = 5'd30; wdata24 = 32'h0000_0BAD;
        tick();
        we24 = 1'b0; ren24 = 1'b1; raddr24 = 5'd30;
        tick();
        checkOutput("d24_rd30_after", 64'(rdata24), 64'd0);
        for (int a = 0; a < 24; a++) begin
            raddr24 = 5'(a);
            tick();
            checkOutput($sformatf("d24_rd_a%0d", a), 64'(rdata24),
                        (a == 3) ? 64'h0000_CAFE : 64'd0);
        end
        ren24 = 1'b0;

        // Reset mid-sweep restarts it; writes during the sweep are ignored
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("restart_busy", 64'(Busy), 64'd1);
        checkOutput("restart_data", ReadData, 64'd0);
        checkOutput("restart_valid", 64'(ReadValid), 64'd0);
        ReadEn = 2'b11; ReadAddr = {5'd5, 5'd2};
        RegWrite = 1'b1; WriteAddr = 5'd2; WriteData = 32'hFFFF_FFFF;
        cnt = 0;
        saw_valid = 1'b0;
        while (Busy && cnt < 100) begin
            tick();
            cnt++;
            if (ReadValid != 2'b00) saw_valid = 1'b1;
        end
        checkOutput("restart_len", 64'(cnt), 64'd32);
        checkOutput("sweep_no_valid", 64'(saw_valid), 64'd0);
        applyStimulus(2'b11, 5'd2, 5'd5, 1'b0, 5'd0, 32'd0);
        checkOutput("sweep_wr_ignored", ReadData, 64'd0);
        checkOutput("sweep_rd_valid", 64'(ReadValid), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the CPU register file: configurable data width, depth and number of read ports, with concurrent read and write in the same cycle. Reads are registered with a valid strobe, and register 0 can be hard-wired to zero. A synchronous reset starts a per-entry clear sweep that reports busy until it finishes. The block sits in the decode stage of the datapath; the pipeline controller stalls on `Busy`.

## Interface
- `WIDTH`, 32, data width in bits.
- `DEPTH`, 32, number of registers (≥2).
- `NUM_RD`, 2, number of read ports (1–4).
- `ZERO_REG`, 1, when 1 register 0 always reads 0 and ignores writes.
- `AW`, derived = clog2(DEPTH), address width (localparam).

Ports:
- `Clock`  in  1  single clock, all logic on rising edge.
- `Reset`  in  1  synchronous, active-high; starts clear sweep.
- `ReadEn`  in  NUM_RD  per-port read request.
- `ReadAddr`  in  NUM_RD*AW  port p at bits [p*AW +: AW].
- `ReadData`  out  NUM_RD*WIDTH  port p at bits [p*WIDTH +: WIDTH], registered.
- `ReadValid`  out  NUM_RD  per-port, high for one cycle with its data.
- `RegWrite`  in  1  write enable.
- `WriteAddr`  in  AW  write address.
- `WriteData`  in  WIDTH  write data.
- `Busy`  out  1  high while the clear sweep is running; requests are ignored.

## Operation
- States: CLEAR and RUN.
- Reset at an edge sets state=CLEAR, sweep pointer=0, `ReadData`=0, `ReadValid`=0, `Busy`=1.
- CLEAR:
  - Each cycle writes 0 to Reg[ptr] and increments ptr.
  - After writing Reg[DEPTH-1], the state goes to RUN and `Busy` falls at that same edge.
  - `RegWrite` and `ReadEn` are ignored; `ReadData` holds 0 and `ReadValid` stays 0.
- RUN, write:
  - If `RegWrite`=1 and `WriteAddr`<DEPTH, Reg[WriteAddr] takes `WriteData`.
  - The write is suppressed when ZERO_REG=1 and `WriteAddr`=0.
- RUN, read (port p):
  - If `ReadEn`[p]=1, the next edge loads `ReadData`[p] and sets `ReadValid`[p]=1.
  - If `ReadEn`[p]=0, `ReadData`[p] holds its last value and `ReadValid`[p]=0.
  - Read value is 0 if `ReadAddr`[p]≥DEPTH, or if ZERO_REG=1 and `ReadAddr`[p]=0.
  - Otherwise the read value is Reg[`ReadAddr`[p]]. Same-cycle write collisions are resolved per Configuration.
- Ports are independent: any number of ports may read the same address in the same cycle.
- Reset asserted mid-sweep or in RUN always restarts the sweep from ptr=0.
- Reset has priority over every other input.

## Timing
- Read latency is 1 cycle: address presented at edge N produces data and valid after edge N+1.
- Write is visible to a read issued at the following edge (or the same edge with bypass enabled).
- Sweep length is exactly DEPTH cycles after the Reset edge, counting the Reset cycle itself. `Busy` is high for DEPTH cycles.
- No combinational path from any input to any output.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read and a write to the same valid, non-suppressed address in the same RUN cycle return `WriteData`.
- `REGFILE_BYPASS_EN` undefined:
  - Such a read returns the old stored value.
  - The new value is visible from the next cycle onward.
- ZERO_REG suppression and the ≥DEPTH rule apply before bypass.

## Structure
- Package `regfile_pkg`:
  - State enum (ST_CLEAR, ST_RUN).
  - clog2 helper function.
  - Default WIDTH/DEPTH constants shared with the decode stage.
- One sub-module, `regfile_clear_seq`:
  - Contains the state register, sweep pointer, `Busy` and the clear write-enable/address.
  - The top-level module muxes the clear write port against the user write port.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset, DEPTH=32 → `Busy`=1 for 32 cycles; then every address reads 0 with `ReadValid`=1 one cycle after `ReadEn`.
- Write 0xDEADBEEF to address 5, read address 5 on both ports next cycle → both `ReadData`=0xDEADBEEF, both `ReadValid`=1.
- ZERO_REG=1: write 0x1234 to address 0, read address 0 → 0x00000000.
- Same-cycle write 0xA5A5A5A5 to address 7 (old value 0x11) with a read of address 7 → 0xA5A5A5A5 with `REGFILE_BYPASS_EN`, 0x00000011 without it.
- Reset asserted at sweep cycle 10 of 32 → sweep restarts; `Busy` stays high 32 more cycles; a `RegWrite` during the sweep leaves its register at 0.
- DEPTH=24: read address 30 → 0; write to address 30 changes no register.
